// File: rtl/reflet_gpio_ext.sv
// reflet_gpio_ext: memory-mapped GPIO on the 8-bit Reflet bus.
// NUM_PINS pins with output latch, direction bit, 2-flop input synchroniser and
// sticky write-1-to-clear rise/fall interrupt status.
// Optional per-pin debounce filter between synchroniser and IN: define GPIO_DEBOUNCE_EN.
`timescale 1ns/1ps
module reflet_gpio_ext #(
   parameter int base_addr_size = 16,
   parameter logic [base_addr_size-1:0] base_addr = 16'hFF00,
   parameter int NUM_PINS = 16,
   parameter logic [NUM_PINS-1:0] RESET_OUT = '0,
   parameter int DEBOUNCE_CYCLES = 16
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [base_addr_size-1:0] addr,
   input  logic                      write_en,
   input  logic [7:0]                data_in,
   output logic [7:0]                data_out,
   output logic                      interrupt,
   input  logic [NUM_PINS-1:0]       gpi,
   output logic [NUM_PINS-1:0]       gpo,
   output logic [NUM_PINS-1:0]       gpo_oe
);

   // Elaboration-time guard on parameter ranges.
   if (NUM_PINS < 1 || NUM_PINS > 64 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_params
      $error("reflet_gpio_ext: NUM_PINS or DEBOUNCE_CYCLES out of range");
   end

   logic [base_addr_size:0] addr_ext;
   logic [base_addr_size:0] lo_ext;
   logic [base_addr_size:0] hi_ext;
   logic                    sel;
   logic [5:0]              offset;
   logic [2:0]              group;
   logic [2:0]              byte_idx;
   logic                    wr;

   // The window end is computed one bit wider so a window ending at the top of
   // the address space does not wrap.
   assign addr_ext = {1'b0, addr};
   assign lo_ext   = {1'b0, base_addr};
   assign hi_ext   = lo_ext + (base_addr_size + 1)'(64);
   assign sel      = enable && (addr_ext >= lo_ext) && (addr_ext < hi_ext);
   assign offset   = 6'(addr - base_addr);
   assign group    = offset[5:3];
   assign byte_idx = offset[2:0];
   assign wr       = sel && write_en;

   logic [NUM_PINS-1:0] lane_mask;
   logic [NUM_PINS-1:0] wr_data;

   // Map the addressed byte lane onto pins; lanes beyond NUM_PINS simply have no bits.
   always_comb begin
      lane_mask = '0;
      wr_data   = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         lane_mask[i] = (3'(i / 8) == byte_idx);
         wr_data[i]   = data_in[i % 8];
      end
   end

   logic [NUM_PINS-1:0] out_q;
   logic [NUM_PINS-1:0] dir_q;
   logic [NUM_PINS-1:0] rise_en_q;
   logic [NUM_PINS-1:0] fall_en_q;
   logic [NUM_PINS-1:0] status_q;

   // Read/write control registers, updated one byte lane at a time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q     <= RESET_OUT;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
      end else if (wr) begin
         case (group)
            3'd0: out_q     <= (out_q & ~lane_mask) | (wr_data & lane_mask);
            3'd1: dir_q     <= (dir_q & ~lane_mask) | (wr_data & lane_mask);
            3'd3: rise_en_q <= (rise_en_q & ~lane_mask) | (wr_data & lane_mask);
            3'd4: fall_en_q <= (fall_en_q & ~lane_mask) | (wr_data & lane_mask);
            default: ;
         endcase
      end
   end

   logic [NUM_PINS-1:0] sync1;
   logic [NUM_PINS-1:0] sync2;
   logic [NUM_PINS-1:0] filt;
   logic [NUM_PINS-1:0] prev;

   // Two-flop synchroniser for the asynchronous pad inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpi;
         sync2 <= sync1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic [15:0] db_cnt [NUM_PINS];

   // Debounce: filt only follows sync2 after DEBOUNCE_CYCLES consecutive mismatches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt <= '0;
         for (int i = 0; i < NUM_PINS; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_PINS; i++) begin
            if (sync2[i] != filt[i]) begin
               if (db_cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                  filt[i]   <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 16'd1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end
`else
   assign filt = sync2;
`endif

   // Previous filtered value, the reference for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) prev <= '0;
      else        prev <= filt;
   end

   logic [NUM_PINS-1:0] rise;
   logic [NUM_PINS-1:0] fall;
   logic [NUM_PINS-1:0] clr_mask;

   assign rise     = filt & ~prev;
   assign fall     = ~filt & prev;
   assign clr_mask = (wr && group == 3'd5) ? (wr_data & lane_mask) : '0;

   // Sticky status: a new edge in the same cycle as a W1C clear keeps the bit set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) status_q <= '0;
      else        status_q <= (status_q & ~clr_mask) | (rise & rise_en_q) | (fall & fall_en_q);
   end

   assign gpo       = out_q;
   assign gpo_oe    = dir_q;
   assign interrupt = |status_q;

   logic [63:0] view;

   // Combinational read mux; unselected accesses return 0 so buses can be OR-ed.
   always_comb begin
      view = '0;
      case (group)
         3'd0: view[NUM_PINS-1:0] = out_q;
         3'd1: view[NUM_PINS-1:0] = dir_q;
         3'd2: view[NUM_PINS-1:0] = filt;
         3'd3: view[NUM_PINS-1:0] = rise_en_q;
         3'd4: view[NUM_PINS-1:0] = fall_en_q;
         3'd5: view[NUM_PINS-1:0] = status_q;
         default: ;
      endcase
      data_out = sel ? view[{byte_idx, 3'b000} +: 8] : 8'h00;
   end

endmodule

// File: tb/tb_reflet_gpio_ext.sv
// tb_reflet_gpio_ext: scoreboard bench for reflet_gpio_ext with NUM_PINS=20.
`timescale 1ns/1ps
module tb_reflet_gpio_ext;

`ifdef GPIO_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif
   localparam logic [15:0] BASE    = 16'hFF00;
   localparam logic [19:0] RST_OUT = 20'h00012;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] addr;
   logic        write_en;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        interrupt;
   logic [19:0] gpi;
   logic [19:0] gpo;
   logic [19:0] gpo_oe;

   reflet_gpio_ext #(
      .base_addr_size(16),
      .base_addr(BASE),
      .NUM_PINS(20),
      .RESET_OUT(RST_OUT),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .addr(addr),
      .write_en(write_en),
      .data_in(data_in),
      .data_out(data_out),
      .interrupt(interrupt),
      .gpi(gpi),
      .gpo(gpo),
      .gpo_oe(gpo_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] value;
   } expect_t;

   expect_t sb_q[$];
   int error_count = 0;
   int check_count = 0;
   logic [19:0] out_model;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic push_expect(input string tag, input logic [63:0] value);
      expect_t e;
      e.tag   = tag;
      e.value = value;
      sb_q.push_back(e);
   endtask

   task automatic pop_compare(input logic [63:0] observed);
      expect_t e;
      if (sb_q.size() == 0) begin
         check_count++;
         error_count++;
         $display("[TB] FAIL scoreboard_empty: got %0h, expected a queued value", observed);
      end else begin
         e = sb_q.pop_front();
         check_output(e.tag, observed, e.value);
      end
   endtask

   task automatic check_now(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      push_expect(tag, expected);
      pop_compare(observed);
   endtask

   task automatic apply_stimulus(input logic [19:0] value);
      @(negedge clk);
      gpi = value;
   endtask

   task automatic bus_write(input logic [5:0] off, input logic [7:0] data);
      @(negedge clk);
      enable   = 1'b1;
      write_en = 1'b1;
      addr     = BASE + 16'(off);
      data_in  = data;
      @(posedge clk);
      #1;
      enable   = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic bus_read_addr(input logic [15:0] a, output logic [7:0] data);
      @(negedge clk);
      enable   = 1'b1;
      write_en = 1'b0;
      addr     = a;
      #1;
      data   = data_out;
      enable = 1'b0;
   endtask

   task automatic expect_read_addr(input string tag, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] d;
      push_expect(tag, 64'(exp));
      bus_read_addr(a, d);
      pop_compare(64'(d));
   endtask

   task automatic expect_read(input string tag, input logic [5:0] off, input logic [7:0] exp);
      expect_read_addr(tag, BASE + 16'(off), exp);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [23:0] tmp;
      logic [7:0]  v;
      int          b;

      reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0; gpi = '0;
      #2 reset = 1'b0;
      #10;
      check_now("rst_gpo", 64'(gpo), 64'(RST_OUT));
      check_now("rst_gpo_oe", 64'(gpo_oe), 64'd0);
      check_now("rst_irq", 64'(interrupt), 64'd0);
      check_now("idle_data_out", 64'(data_out), 64'd0);
      #10 reset = 1'b1;
      out_model = RST_OUT;
      expect_read("rst_out_b0", 6'd0, 8'h12);
      expect_read("rst_status_b0", 6'd40, 8'h00);

      $display("[TB] register access");
      bus_write(6'd0, 8'hA5);
      bus_write(6'd1, 8'h3C);
      bus_write(6'd2, 8'hFF);
      out_model = 20'hF3CA5;
      check_now("gpo_bytes", 64'(gpo), 64'h0F3CA5);
      expect_read("out_b2_partial", 6'd2, 8'h0F);
      expect_read("out_b3_absent", 6'd3, 8'h00);
      expect_read("out_b0", 6'd0, 8'hA5);

      bus_write(6'd8, 8'h0F);
      check_now("gpo_oe", 64'(gpo_oe), 64'h0000F);
      expect_read("dir_b0", 6'd8, 8'h0F);
      expect_read_addr("read_above_window", BASE + 16'd64, 8'h00);
      expect_read_addr("read_below_window", BASE - 16'd1, 8'h00);
      bus_write(6'd48, 8'hFF);
      expect_read("reserved_g6", 6'd48, 8'h00);
      bus_write(6'd16, 8'hFF);
      expect_read("in_ro", 6'd16, 8'h00);
      @(negedge clk);
      addr = BASE; enable = 1'b0; #1;
      check_now("unselected_zero", 64'(data_out), 64'd0);

      for (int k = 0; k < 4; k++) begin
         b = $urandom_range(0, 2);
         v = 8'($urandom_range(0, 255));
         tmp = {4'b0, out_model};
         tmp[b*8 +: 8] = v;
         out_model = tmp[19:0];
         tmp = {4'b0, out_model};
         bus_write(6'(b), v);
         check_now("gpo_rand", 64'(gpo), 64'(out_model));
         expect_read("out_rand_rb", 6'(b), tmp[b*8 +: 8]);
      end

      $display("[TB] rising edge and W1C");
      bus_write(6'd24, 8'h08);
      apply_stimulus(20'h00008);
      repeat (DB) @(negedge clk);
      expect_read("in_b3_early", 6'd16, 8'h00);
      expect_read("in_b3", 6'd16, 8'h08);
      check_now("irq_not_yet", 64'(interrupt), 64'd0);
      expect_read("status_rise3", 6'd40, 8'h08);
      check_now("irq_rise3", 64'(interrupt), 64'd1);
      bus_write(6'd40, 8'h08);
      check_now("irq_cleared", 64'(interrupt), 64'd0);
      expect_read("status_cleared", 6'd40, 8'h00);

      $display("[TB] falling edge with concurrent clear");
      bus_write(6'd24, 8'h00);
      bus_write(6'd32, 8'h01);
      apply_stimulus(20'h00009);
      repeat (4 + DB) @(negedge clk);
      expect_read("status_no_rise", 6'd40, 8'h00);
      check_now("irq_no_rise", 64'(interrupt), 64'd0);
      apply_stimulus(20'h00008);
      repeat (1 + DB) @(negedge clk);
      bus_write(6'd40, 8'h01);
      check_now("irq_set_wins", 64'(interrupt), 64'd1);
      expect_read("status_set_wins", 6'd40, 8'h01);
      bus_write(6'd40, 8'h01);
      check_now("irq_fall_cleared", 64'(interrupt), 64'd0);

      bus_write(6'd24, 8'h08);
      repeat (4 + DB) @(negedge clk);
      expect_read("no_retro_rise", 6'd40, 8'h00);

      $display("[TB] asynchronous reset");
      bus_write(6'd32, 8'h00);
      bus_write(6'd24, 8'h00);
      apply_stimulus(20'h00000);
      repeat (4 + DB) @(negedge clk);
      bus_write(6'd0, 8'h55);
      out_model[7:0] = 8'h55;
      bus_write(6'd24, 8'hFF);
      apply_stimulus(20'h000FF);
      repeat (4 + DB) @(negedge clk);
      expect_read("status_all", 6'd40, 8'hFF);
      check_now("irq_all", 64'(interrupt), 64'd1);
      check_now("gpo_pre_reset", 64'(gpo), 64'(out_model));
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_now("async_irq", 64'(interrupt), 64'd0);
      check_now("async_gpo", 64'(gpo), 64'(RST_OUT));
      check_now("async_gpo_oe", 64'(gpo_oe), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      out_model = RST_OUT;
      expect_read("post_reset_status", 6'd40, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
      $display("[TB] debounce");
      apply_stimulus(20'h00000);
      repeat (10) @(negedge clk);
      bus_write(6'd24, 8'h02);
      apply_stimulus(20'h00002);
      repeat (3) @(negedge clk);
      gpi = 20'h00000;
      repeat (12) @(negedge clk);
      expect_read("glitch_in", 6'd16, 8'h00);
      expect_read("glitch_status", 6'd40, 8'h00);
      check_now("glitch_irq", 64'(interrupt), 64'd0);
      apply_stimulus(20'h00002);
      repeat (DB) @(negedge clk);
      expect_read("db_in_early", 6'd16, 8'h00);
      expect_read("db_in", 6'd16, 8'h02);
      expect_read("db_status", 6'd40, 8'h02);
`endif

      if (sb_q.size() != 0) begin
         check_count++;
         error_count++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
